// File: rtl/rvx_latency_ram_pkg.sv
// -----------------------------------------------------------------------------
// rvx_latency_ram_pkg
// Shared definitions for the fixed-latency test RAM:
//   - state_e    : transaction state machine encoding (IDLE / BUSY / RESPOND)
//   - CNT_W      : width of the latency down-counter
//   - LFSR_SEED  : reset value of the stall-injection LFSR
//   - LFSR_TAPS  : Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1)
//   - merge_word : byte-strobe merge of a write word into an old word
// -----------------------------------------------------------------------------
package rvx_latency_ram_pkg;

    localparam int unsigned CNT_W     = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Replace the bytes of old_word selected by strb with the bytes of wdata.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rvx_lfsr16.sv
// -----------------------------------------------------------------------------
// rvx_lfsr16
// 16-bit maximal-length Galois LFSR used to pick per-request stall cycles.
// Ports:
//   clock   in   sole clock, rising edge
//   reset   in   asynchronous active-low reset (loads LFSR_SEED)
//   advance in   step the register by one position
//   value   out  current register contents
// -----------------------------------------------------------------------------
module rvx_lfsr16
    import rvx_latency_ram_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Galois right-shift step: feed the shifted-out bit back through the tap mask.
    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
        end else begin
            value_d = value_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/rvx_latency_ram.sv
// -----------------------------------------------------------------------------
// rvx_latency_ram
// Single-port word RAM with programmable read/write latency and a tohost
// test-completion monitor. One transaction at a time; requests are held by the
// requester until the matching response pulse.
//
// Optional feature: define RVX_LATENCY_RAM_STALL_INJECT_EN to add 0..3 random
// BUSY cycles per accepted request (taken from a 16-bit LFSR).
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous active-low reset
//   rw_address     in   byte address (bits [1:0] ignored, wraps mod MEMORY_SIZE)
//   read_data      out  read word, valid in the read_response cycle
//   read_request   in   read request
//   read_response  out  one-cycle read completion pulse
//   write_data     in   write word
//   write_strobe   in   byte enables
//   write_request  in   write request
//   write_response out  one-cycle write completion pulse
//   test_done      out  sticky completion flag
//   test_pass      out  sticky pass flag (completion value == 1)
//   test_code      out  write_data[31:1] of the completion write
//
// Timing: the response pulse is visible in the cycle that starts L edges after
// the acceptance edge. The FSM is in RESPOND the cycle before; the write
// commits and read_data is captured on the edge leaving RESPOND. Requests are
// not accepted while a response pulse is showing, because the requester still
// holds its request during that cycle.
// -----------------------------------------------------------------------------
module rvx_latency_ram
    import rvx_latency_ram_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE    = 2097152,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_LATENCY  = 1,
    parameter logic [31:0] TOHOST_ADDRESS = 32'h0000_1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    input  logic        write_request,
    output logic        write_response,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] test_code
);

    localparam int unsigned WORDS        = MEMORY_SIZE / 4;
    localparam int unsigned IDX_W        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BOTH_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                          : WRITE_LATENCY;
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0] BOTH_LOAD = CNT_W'(BOTH_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [29:0]      WORD_MASK = 30'(WORDS - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic              is_rd_q;
    logic              is_wr_q;
    logic [31:0]       read_data_q;
    logic              rd_rsp_q;
    logic              wr_rsp_q;
    logic              done_q;
    logic              pass_q;
    logic [30:0]       code_q;

    logic [31:0]       mem_q [WORDS];

    logic              accept_s;
    logic [CNT_W-1:0]  load_s;
    logic [IDX_W-1:0]  idx_s;
    logic [31:0]       merged_s;
    logic              commit_s;
    logic              tohost_hit_s;

`ifdef RVX_LATENCY_RAM_STALL_INJECT_EN
    logic [15:0]       lfsr_value_s;
    logic [1:0]        stall_load_s;
    logic [1:0]        stall_q;

    rvx_lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (accept_s),
        .value   (lfsr_value_s)
    );

    assign stall_load_s = lfsr_value_s[1:0];
`endif

    assign accept_s     = (state_q == ST_IDLE) && (read_request || write_request)
                          && !(rd_rsp_q || wr_rsp_q);
    assign idx_s        = IDX_W'(addr_q & WORD_MASK);
    // A combined read+write returns the post-write word, so reads see the merge too.
    assign merged_s     = merge_word(mem_q[idx_s], wdata_q, is_wr_q ? strb_q : 4'b0000);
    assign commit_s     = (state_q == ST_RESPOND) && is_wr_q;
    assign tohost_hit_s = (addr_q == TOHOST_ADDRESS[31:2]);

    // Counter load value: a combined request waits for the slower of the two.
    always_comb begin
        load_s = WR_LOAD;
        if (read_request && write_request) begin
            load_s = BOTH_LOAD;
        end else if (read_request) begin
            load_s = RD_LOAD;
        end else begin
            load_s = WR_LOAD;
        end
    end

    // Transaction FSM with request latches and registered response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            addr_q      <= 30'd0;
            wdata_q     <= 32'd0;
            strb_q      <= 4'd0;
            is_rd_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            read_data_q <= 32'd0;
            rd_rsp_q    <= 1'b0;
            wr_rsp_q    <= 1'b0;
`ifdef RVX_LATENCY_RAM_STALL_INJECT_EN
            stall_q     <= 2'd0;
`endif
        end else begin
            rd_rsp_q <= 1'b0;
            wr_rsp_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_q  <= rw_address[31:2];
                        wdata_q <= write_data;
                        strb_q  <= write_strobe;
                        is_rd_q <= read_request;
                        is_wr_q <= write_request;
                        cnt_q   <= load_s;
`ifdef RVX_LATENCY_RAM_STALL_INJECT_EN
                        stall_q <= stall_load_s;
                        if ((load_s == CNT_ZERO) && (stall_load_s == 2'd0)) begin
                            state_q <= ST_RESPOND;
                        end else begin
                            state_q <= ST_BUSY;
                        end
`else
                        if (load_s == CNT_ZERO) begin
                            state_q <= ST_RESPOND;
                        end else begin
                            state_q <= ST_BUSY;
                        end
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
`ifdef RVX_LATENCY_RAM_STALL_INJECT_EN
                    // Stall cycles are spent first; a latency-1 request leaves BUSY
                    // as the last stall cycle is consumed.
                    if (stall_q != 2'd0) begin
                        stall_q <= stall_q - 2'd1;
                        if ((stall_q == 2'd1) && (cnt_q == CNT_ZERO)) begin
                            state_q <= ST_RESPOND;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end else if (cnt_q <= CNT_ONE) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= ST_RESPOND;
                    end else begin
                        cnt_q   <= cnt_q - CNT_ONE;
                        state_q <= ST_BUSY;
                    end
`else
                    if (cnt_q <= CNT_ONE) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= ST_RESPOND;
                    end else begin
                        cnt_q   <= cnt_q - CNT_ONE;
                        state_q <= ST_BUSY;
                    end
`endif
                end
                ST_RESPOND: begin
                    rd_rsp_q <= is_rd_q;
                    wr_rsp_q <= is_wr_q;
                    if (is_rd_q) begin
                        read_data_q <= merged_s;
                    end else begin
                        read_data_q <= read_data_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Test-completion monitor: only the first qualifying tohost write is recorded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
            code_q <= 31'd0;
        end else if (commit_s && tohost_hit_s && wdata_q[0] && !done_q) begin
            done_q <= 1'b1;
            pass_q <= (wdata_q == 32'h0000_0001);
            code_q <= wdata_q[31:1];
        end else begin
            done_q <= done_q;
            pass_q <= pass_q;
            code_q <= code_q;
        end
    end

    // Memory array: no reset, contents come from the requester. Since the FSM is
    // forced to IDLE by reset, an aborted write never reaches this commit.
    always_ff @(posedge clock) begin
        if (commit_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

    assign read_data      = read_data_q;
    assign read_response  = rd_rsp_q;
    assign write_response = wr_rsp_q;
    assign test_done      = done_q;
    assign test_pass      = pass_q;
    assign test_code      = code_q;

endmodule
